// File: rtl/ssp_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ssp_rx_fifo_pkg
// Shared SSP definitions: word width, FIFO geometry and the serial FSM state
// encoding. The transmit side of the SSP imports the same package so both
// directions agree on framing and buffer sizes.
// ---------------------------------------------------------------------------
package ssp_rx_fifo_pkg;

  localparam int unsigned SSP_DATA_W     = 8;
  localparam int unsigned SSP_FIFO_DEPTH = 4;
  localparam int unsigned SSP_PTR_W      = 2;

  // Serial FSM states; IDLE waits for a frame sync, SHIFT collects bits.
  typedef enum logic {
    SSP_RX_IDLE  = 1'b0,
    SSP_RX_SHIFT = 1'b1
  } ssp_rx_state_e;

endpackage

// File: rtl/ssp_sync_fifo.sv
// ---------------------------------------------------------------------------
// ssp_sync_fifo
// Generic single-clock push/pop FIFO. A push into a full FIFO is refused
// (contents untouched) unless a pop is accepted in the same cycle, in which
// case both happen and the occupancy stays at DEPTH.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset (pointers/count only)
//   push       in   write request
//   push_data  in   DATA_W word to write
//   pop        in   read request; ignored while empty
//   pop_data   out  head word, 0 while empty
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  occupancy, 0..DEPTH
//   overrun    out  push refused this cycle (full, no simultaneous pop)
// ---------------------------------------------------------------------------
module ssp_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overrun
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_done;
  logic              push_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign pop_done = pop & ~empty;
  // When full, the write slot is the head slot; it is only free if the head
  // leaves on this same edge.
  assign push_ok  = push & (~full | pop_done);
  assign overrun  = push & ~push_ok;

  assign pop_data = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (pop_done) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_done})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because the
  // read port is gated by the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ssp_rx_fifo.sv
// ---------------------------------------------------------------------------
// ssp_rx_fifo
// Receive half of the SSP. Deserialises SSPRXD (MSB first) on rising edges of
// SSPCLKIN, framed by a one-period SSPFSSIN pulse, and buffers the resulting
// words in a small FIFO that the bus drains through PSEL/PWRITE/PRDATA.
//
// Ports:
//   PCLK        in   system clock
//   CLEAR_B     in   asynchronous active-low reset
//   PSEL        in   chip select; a read happens only when high
//   PWRITE      in   0 = read access; writes are ignored
//   SSPCLKIN    in   serial clock (PCLK/2, synchronous to PCLK)
//   SSPFSSIN    in   frame sync
//   SSPRXD      in   serial data
//   PRDATA      out  FIFO head word, 0 when empty
//   SSPRXINTR   out  high while the FIFO is full
//   SSPRORINTR  out  overrun flag (only with SSP_RX_OVERRUN_EN defined)
//
// Build option: define SSP_RX_OVERRUN_EN to add the sticky SSPRORINTR
// overrun flag; without it an overrun silently drops the incoming word.
// ---------------------------------------------------------------------------
module ssp_rx_fifo
  import ssp_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = SSP_DATA_W,
  parameter int unsigned DEPTH  = SSP_FIFO_DEPTH,
  parameter int unsigned PTR_W  = SSP_PTR_W
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              PSEL,
  input  logic              PWRITE,
  input  logic              SSPCLKIN,
  input  logic              SSPFSSIN,
  input  logic              SSPRXD,
  output logic [DATA_W-1:0] PRDATA,
  output logic              SSPRXINTR
`ifdef SSP_RX_OVERRUN_EN
  ,
  output logic              SSPRORINTR
`endif
);

  localparam int unsigned BIT_W = $clog2(DATA_W);

  ssp_rx_state_e     state_q, state_d;
  logic              clk_d_q;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  // Only the first DATA_W-1 bits need storing; the last bit goes straight
  // from SSPRXD into the pushed word.
  logic [DATA_W-2:0] sr_q, sr_d;

  logic              rise;
  logic              push;
  logic [DATA_W-1:0] push_word;
  logic              pop_req;

  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PTR_W:0]    fifo_count;
  logic              fifo_overrun;

  assign rise      = SSPCLKIN & ~clk_d_q;
  assign push_word = {sr_q, SSPRXD};
  assign pop_req   = PSEL & ~PWRITE;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    push     = 1'b0;
    if (rise) begin
      case (state_q)
        SSP_RX_IDLE: begin
          if (SSPFSSIN) begin
            state_d  = SSP_RX_SHIFT;
            bitcnt_d = '0;
          end
        end
        SSP_RX_SHIFT: begin
          sr_d = push_word[DATA_W-2:0];
          if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
            push     = 1'b1;
            bitcnt_d = '0;
            // Sync on the final bit chains straight into the next frame.
            state_d  = SSPFSSIN ? SSP_RX_SHIFT : SSP_RX_IDLE;
          end else begin
            bitcnt_d = bitcnt_q + BIT_W'(1);
          end
        end
        default: state_d = SSP_RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q  <= SSP_RX_IDLE;
      clk_d_q  <= 1'b0;
      bitcnt_q <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      clk_d_q  <= SSPCLKIN;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
    end
  end

  ssp_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk       (PCLK),
    .rst_n     (CLEAR_B),
    .push      (push),
    .push_data (push_word),
    .pop       (pop_req),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overrun   (fifo_overrun)
  );

  assign PRDATA    = fifo_rd_data;
  // Driven from the registered count, so it follows a push/pop by one cycle.
  assign SSPRXINTR = fifo_full;

`ifdef SSP_RX_OVERRUN_EN
  logic ror_q, ror_d;
  logic pop_ok;
  logic unused_fifo;

  assign pop_ok      = pop_req & (fifo_count != '0);
  assign unused_fifo = fifo_empty;

  always_comb begin
    ror_d = ror_q;
    if (pop_ok) begin
      ror_d = 1'b0;
    end
    // A drop on the same edge as the clearing read keeps the flag set.
    if (fifo_overrun) begin
      ror_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      ror_q <= 1'b0;
    end else begin
      ror_q <= ror_d;
    end
  end

  assign SSPRORINTR = ror_q;
`else
  logic unused_fifo;
  assign unused_fifo = ^{fifo_empty, fifo_count, fifo_overrun};
`endif

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ssp_rx_fifo
// Directed plus randomised stimulus for ssp_rx_fifo. The reference model is a
// byte queue: a frame's word is appended when its last bit is clocked in,
// dropped if four words are already held and no read leaves on that edge,
// and a bus read removes the head.
// ---------------------------------------------------------------------------
module tb_ssp_rx_fifo;

  logic       PCLK;
  logic       CLEAR_B;
  logic       PSEL;
  logic       PWRITE;
  logic       SSPCLKIN;
  logic       SSPFSSIN;
  logic       SSPRXD;
  logic [7:0] PRDATA;
  logic       SSPRXINTR;
`ifdef SSP_RX_OVERRUN_EN
  logic       SSPRORINTR;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q [$];
  bit         model_ror;

  ssp_rx_fifo dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .SSPCLKIN  (SSPCLKIN),
    .SSPFSSIN  (SSPFSSIN),
    .SSPRXD    (SSPRXD),
    .PRDATA    (PRDATA),
    .SSPRXINTR (SSPRXINTR)
`ifdef SSP_RX_OVERRUN_EN
    ,
    .SSPRORINTR(SSPRORINTR)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] model_head();
    return (model_q.size() != 0) ? model_q[0] : 8'h00;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model effect of one PCLK edge: read first, then an arriving word.
  task automatic model_edge(input bit rd, input bit do_push, input logic [7:0] w);
    if (rd && model_q.size() != 0) begin
      void'(model_q.pop_front());
      model_ror = 1'b0;
    end
    if (do_push) begin
      if (model_q.size() < 4) model_q.push_back(w);
      else model_ror = 1'b1;
    end
  endtask

  task automatic post_checks(input string tag);
    chk8({tag, "_prdata"}, PRDATA, model_head());
    chk1({tag, "_rxintr"}, SSPRXINTR, model_q.size() == 4);
`ifdef SSP_RX_OVERRUN_EN
    chk1({tag, "_rorintr"}, SSPRORINTR, model_ror);
`endif
  endtask

  // One serial period (two PCLKs), entered and left at posedge+1.
  // rd asserts a bus read during the PCLK whose edge samples this bit.
  task automatic rise(input bit fss, input bit d, input bit rd,
                      input bit do_push, input logic [7:0] w);
    SSPCLKIN = 1'b0; SSPFSSIN = fss; SSPRXD = d; PSEL = 1'b0; PWRITE = 1'b0;
    @(posedge PCLK); #1;
    SSPCLKIN = 1'b1; PSEL = rd;
    if (rd) chk8("read_data", PRDATA, model_head());
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    model_edge(rd, do_push, w);
    if (do_push)
      $display("frame word=%h depth=%0d", w, model_q.size());
    post_checks("rise");
  endtask

  task automatic bus(input bit wr);
    PSEL = 1'b1; PWRITE = wr;
    if (!wr) chk8("bus_read", PRDATA, model_head());
    $display("bus %s prdata=%h", wr ? "write" : "read", PRDATA);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PWRITE = 1'b0;
    model_edge(!wr, 1'b0, 8'h00);
    post_checks("bus");
  endtask

  // Send one word. with_fss emits the sync period first; b2b raises sync
  // on the last bit; noise toggles sync randomly on the inner bits.
  task automatic send_frame(input logic [7:0] b, input bit with_fss, input bit b2b,
                            input bit rd_lsb, input int rd_pct, input bit noise);
    bit rd;
    bit fss;
    if (with_fss) rise(1'b1, 1'($urandom), 1'b0, 1'b0, 8'h00);
    for (int i = 7; i >= 0; i--) begin
      rd  = (i == 0) ? rd_lsb : (rd_pct > 0 && $urandom_range(99) < rd_pct);
      fss = (i == 0) ? b2b : (noise && $urandom_range(1) == 1);
      rise(fss, b[i], rd, i == 0, b);
    end
  endtask

  initial begin
    logic [7:0] w;
    bit         prev_b2b;
    bit         b2b;

    model_ror = 1'b0;
    CLEAR_B = 1'b0; PSEL = 1'b0; PWRITE = 1'b0;
    SSPCLKIN = 1'b0; SSPFSSIN = 1'b0; SSPRXD = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    post_checks("reset");
    CLEAR_B = 1'b1;

    // Reset in the middle of a frame discards held and partial words.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    rise(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rise(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    rise(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rise(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    CLEAR_B = 1'b0; SSPCLKIN = 1'b0; SSPFSSIN = 1'b0;
    #1;
    model_q.delete();
    model_ror = 1'b0;
    post_checks("midreset");
    @(posedge PCLK); @(posedge PCLK); #1;
    CLEAR_B = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk8("after_reset_word", PRDATA, 8'h3C);
    bus(1'b0);
    bus(1'b0);

    // Single frame, then pop.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk8("single_latency", PRDATA, 8'hA5);
    bus(1'b1);
    bus(1'b0);
    chk8("single_empty", PRDATA, 8'h00);

    // Back-to-back frames.
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h80, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk8("b2b_first", PRDATA, 8'h01);
    bus(1'b0);
    chk8("b2b_second", PRDATA, 8'h80);
    bus(1'b0);

    // Fill, then overrun.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk1("fill_intr", SSPRXINTR, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk8("overrun_head", PRDATA, 8'h11);
    bus(1'b0);
    chk1("fill_intr_fall", SSPRXINTR, 1'b0);
    chk8("overrun_next", PRDATA, 8'h22);
    bus(1'b0); bus(1'b0); bus(1'b0); bus(1'b0);

    // Push/pop collision on a full FIFO.
    send_frame(8'hA1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'hA2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'hA4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h66, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk1("collide_full", SSPRXINTR, 1'b1);
    while (model_q.size() > 1) bus(1'b0);
    chk8("collide_last", PRDATA, 8'h66);
    bus(1'b0);

    // Randomised traffic.
    prev_b2b = 1'b0;
    for (int n = 0; n < 60; n++) begin
      w   = 8'($urandom);
      b2b = ($urandom_range(99) < 30);
      if (!prev_b2b && $urandom_range(3) == 0)
        rise(1'b0, 1'($urandom), 1'b0, 1'b0, 8'h00);
      send_frame(w, !prev_b2b, b2b, $urandom_range(99) < 25, 15, !prev_b2b && $urandom_range(1) == 1);
      prev_b2b = b2b;
      if (!b2b && $urandom_range(2) == 0) bus(1'($urandom_range(3) == 0));
    end
    while (model_q.size() > 0) bus(1'b0);
    bus(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
